// File: rtl/idct_transpose_buf.sv
// Ping-pong 4x4 transpose buffer between the row and column passes of the 4-point IDCT.
// Samples are written row-major one per cycle and read back one column (4 samples) per cycle.
module idct_transpose_buf #(
  parameter int W       = 25,
  parameter bit CLIP_EN = 1'b1,
  parameter int CLIP_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] d_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] d_out_1,
  output logic signed [W-1:0] d_out_2,
  output logic signed [W-1:0] d_out_3,
  output logic signed [W-1:0] d_out_4,
  output logic                out_last
);

  localparam logic signed [W-1:0] SAT_MAX = {{(W-CLIP_W+1){1'b0}}, {(CLIP_W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W-CLIP_W+1){1'b1}}, {(CLIP_W-1){1'b0}}};

  function automatic logic signed [W-1:0] sat(input logic signed [W-1:0] d);
    if (!CLIP_EN)
      return d;
    if (d > SAT_MAX)
      return SAT_MAX;
    if (d < SAT_MIN)
      return SAT_MIN;
    return d;
  endfunction

  logic signed [W-1:0] mem [2][4][4];
  logic [1:0]          full;
  logic                wr_bank;
  logic                rd_bank;
  logic [3:0]          wr_cnt;
  logic [1:0]          rd_col;
  logic                wr_fire;
  logic                rd_fire;
  logic signed [W-1:0] sample_p0;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid && (rd_col == 2'd3);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign sample_p0 = sat(d_in);

  // Read port: the read bank is full, so the write bank never aliases it.
  assign d_out_1 = mem[rd_bank][0][rd_col];
  assign d_out_2 = mem[rd_bank][1][rd_col];
  assign d_out_3 = mem[rd_bank][2][rd_col];
  assign d_out_4 = mem[rd_bank][3][rd_col];

  // Stage 0 -> storage: saturated sample lands at [row][col] of the write bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            mem[b][r][c] <= '0;
    end else if (wr_fire) begin
      mem[wr_bank][wr_cnt[3:2]][wr_cnt[1:0]] <= sample_p0;
    end
  end

  // The two full flags are touched by different sides and never by both on one bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_col  <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == 4'd15) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 4'd1;
        end
      end
      if (rd_fire) begin
        if (rd_col == 2'd3) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          rd_col        <= '0;
        end else begin
          rd_col <= rd_col + 2'd1;
        end
      end
    end
  end

endmodule
